// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, ALU-control, pcsel/wb_sel encodings and execute-register layout
package riscv_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10
  } pcsel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] pc4;
  } ex_t;

  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt, input logic is_op, input logic is_imm);
    if (!(is_op || is_imm)) return ALU_ADD;
    case (f3)
      3'd0:    return (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: XLEN-bit wrap-around integer ALU
module alu_core
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y
);
  always_comb begin
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end
endmodule

// File: rtl/decode_exec_unit.sv
// decode_exec_unit: RV32I decode, branch/jump resolution and execute register; BRANCH_FWD_EN forwards alu_out_m into branch/JALR operands
module decode_exec_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] rs1_d,
  input  logic [XLEN-1:0] rs2_d,
  input  logic [XLEN-1:0] alu_out_m,
  input  logic            fwd1_d,
  input  logic            fwd2_d,
  input  logic            flush_e,
  output logic [1:0]      pcsel,
  output logic [XLEN-1:0] jtarg,
  output logic [XLEN-1:0] btarg,
  output logic            reg_write_e,
  output logic [1:0]      wb_sel_e,
  output logic [4:0]      rd_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [XLEN-1:0] alu_out_e
);
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [31:0] src1, src2, op_a, op_b;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op;
  logic        eq, lt, ltu, taken;
  ex_t         ex_d, ex_q;

  assign opc      = instr_d[6:0];
  assign f3       = instr_d[14:12];
  assign imm_i    = {{20{instr_d[31]}}, instr_d[31:20]};
  assign imm_s    = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b    = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
  assign imm_u    = {instr_d[31:12], 12'b0};
  assign imm_j    = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BRANCH;
  assign is_load  = opc == OPC_LOAD;
  assign is_store = opc == OPC_STORE;
  assign is_opimm = opc == OPC_OPIMM;
  assign is_op    = opc == OPC_OP;

`ifdef BRANCH_FWD_EN
  assign src1 = fwd1_d ? alu_out_m : rs1_d;
  assign src2 = fwd2_d ? alu_out_m : rs2_d;
`else
  logic unused_fwd;
  assign src1       = rs1_d;
  assign src2       = rs2_d;
  assign unused_fwd = ^{alu_out_m, fwd1_d, fwd2_d};
`endif

  always_comb begin
    imm   = (is_lui || is_auipc) ? imm_u : is_jal ? imm_j : is_store ? imm_s : imm_i;
    op_a  = is_lui ? '0 : (is_auipc || is_jal) ? pc_d : rs1_d;
    op_b  = (is_op || is_br) ? rs2_d : imm;
    eq    = src1 == src2;
    lt    = $signed(src1) < $signed(src2);
    ltu   = src1 < src2;
    // funct3 010/011 are not branch conditions and never take
    taken = (f3 == 3'd0) ? eq : (f3 == 3'd1) ? !eq : (f3 == 3'd4) ? lt :
            (f3 == 3'd5) ? !lt : (f3 == 3'd6) ? ltu : (f3 == 3'd7) ? !ltu : 1'b0;
    pcsel = (is_jal || is_jalr) ? PC_JUMP : (is_br && taken) ? PC_BRANCH : PC_PLUS4;
    jtarg = is_jalr ? ((src1 + imm_i) & ~32'd1) : (pc_d + imm_j);
    btarg = pc_d + imm_b;
    ex_d  = '0;
    if (!flush_e) begin
      ex_d.a         = op_a;
      ex_d.b         = op_b;
      ex_d.op        = alu_dec(f3, instr_d[30], is_op, is_opimm);
      ex_d.reg_write = is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op;
      ex_d.wb_sel    = is_load ? WB_MEM : (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
      ex_d.rd        = instr_d[11:7];
      ex_d.funct3    = f3;
      ex_d.pc4       = pc_d + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex_q <= '0;
    else ex_q <= ex_d;

  assign reg_write_e = ex_q.reg_write;
  assign wb_sel_e    = ex_q.wb_sel;
  assign rd_e        = ex_q.rd;
  assign funct3_e    = ex_q.funct3;
  assign pc_plus4_e  = ex_q.pc4;

  alu_core #(.XLEN(XLEN)) u_alu (
    .a  (ex_q.a),
    .b  (ex_q.b),
    .op (ex_q.op),
    .y  (alu_out_e)
  );
endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: directed self-checking bench for decode_exec_unit
module tb_decode_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = '0, pc_d = '0, rs1_d = '0, rs2_d = '0, alu_out_m = '0;
  logic        fwd1_d = 1'b0, fwd2_d = 1'b0, flush_e = 1'b0;
  logic [1:0]  pcsel, wb_sel_e;
  logic [31:0] jtarg, btarg, pc_plus4_e, alu_out_e;
  logic        reg_write_e;
  logic [4:0]  rd_e;
  logic [2:0]  funct3_e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .alu_out_m(alu_out_m), .fwd1_d(fwd1_d), .fwd2_d(fwd2_d), .flush_e(flush_e),
    .pcsel(pcsel), .jtarg(jtarg), .btarg(btarg), .reg_write_e(reg_write_e), .wb_sel_e(wb_sel_e),
    .rd_e(rd_e), .funct3_e(funct3_e), .pc_plus4_e(pc_plus4_e), .alu_out_e(alu_out_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    instr_d = i; pc_d = p; rs1_d = a; rs2_d = b;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex_zero(input string tag);
    chk({tag, "_rw"}, {31'd0, reg_write_e}, 32'd0);
    chk({tag, "_wb"}, {30'd0, wb_sel_e}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd_e}, 32'd0);
    chk({tag, "_f3"}, {29'd0, funct3_e}, 32'd0);
    chk({tag, "_pc4"}, pc_plus4_e, 32'd0);
    chk({tag, "_alu"}, alu_out_e, 32'd0);
  endtask

  initial begin
    #2;
    chk_ex_zero("reset");
    rst_n = 1'b1;
    // ADDI x1,x0,-1
    drv(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    chk("addi_pcsel", {30'd0, pcsel}, 32'd0);
    tick;
    chk("addi_alu", alu_out_e, 32'hFFFFFFFF);
    chk("addi_rw", {31'd0, reg_write_e}, 32'd1);
    chk("addi_wb", {30'd0, wb_sel_e}, 32'd0);
    chk("addi_rd", {27'd0, rd_e}, 32'd1);
    chk("addi_pc4", pc_plus4_e, 32'h4);
    // BEQ x1,x2,-8 at 0x100
    drv(32'hFE208CE3, 32'h100, 32'd5, 32'd5);
    chk("beq_taken", {30'd0, pcsel}, 32'd2);
    chk("beq_btarg", btarg, 32'hF8);
    drv(32'hFE208CE3, 32'h100, 32'd5, 32'd6);
    chk("beq_nt", {30'd0, pcsel}, 32'd0);
    tick;
    chk("beq_rw", {31'd0, reg_write_e}, 32'd0);
    chk("beq_f3", {29'd0, funct3_e}, 32'd0);
    // BLTU / BLT with 1 vs 0xFFFFFFFF
    drv(32'hFE20ECE3, 32'h100, 32'd1, 32'hFFFFFFFF);
    chk("bltu_taken", {30'd0, pcsel}, 32'd2);
    drv(32'hFE20CCE3, 32'h100, 32'd1, 32'hFFFFFFFF);
    chk("blt_nt", {30'd0, pcsel}, 32'd0);
    // JALR x1,0(x5)
    drv(32'h000280E7, 32'h200, 32'h1003, 32'h0);
    chk("jalr_pcsel", {30'd0, pcsel}, 32'd1);
    chk("jalr_jtarg", jtarg, 32'h1002);
    tick;
    chk("jalr_wb", {30'd0, wb_sel_e}, 32'd2);
    chk("jalr_pc4", pc_plus4_e, 32'h204);
    chk("jalr_rw", {31'd0, reg_write_e}, 32'd1);
    // JAL x1,+8 at 0x100
    drv(32'h008000EF, 32'h100, 32'h0, 32'h0);
    chk("jal_pcsel", {30'd0, pcsel}, 32'd1);
    chk("jal_jtarg", jtarg, 32'h108);
    tick;
    chk("jal_alu", alu_out_e, 32'h108);
    // SRAI / SRLI by 4 on 0x80000000
    drv(32'h4040D193, 32'h0, 32'h80000000, 32'h0);
    tick;
    chk("srai", alu_out_e, 32'hF8000000);
    chk("srai_f3", {29'd0, funct3_e}, 32'd5);
    drv(32'h0040D193, 32'h0, 32'h80000000, 32'h0);
    tick;
    chk("srli", alu_out_e, 32'h08000000);
    // SLTU / SLT / SUB / ADD with 1 vs 0xFFFFFFFF
    drv(32'h0020B1B3, 32'h0, 32'd1, 32'hFFFFFFFF);
    tick;
    chk("sltu", alu_out_e, 32'd1);
    drv(32'h0020A1B3, 32'h0, 32'd1, 32'hFFFFFFFF);
    tick;
    chk("slt", alu_out_e, 32'd0);
    drv(32'h402081B3, 32'h0, 32'd1, 32'hFFFFFFFF);
    tick;
    chk("sub", alu_out_e, 32'd2);
    drv(32'h002081B3, 32'h0, 32'd1, 32'hFFFFFFFF);
    tick;
    chk("add_wrap", alu_out_e, 32'd0);
    // LW x5,4(x1) / SW x2,8(x1)
    drv(32'h0040A283, 32'h0, 32'h100, 32'h0);
    tick;
    chk("lw_alu", alu_out_e, 32'h104);
    chk("lw_wb", {30'd0, wb_sel_e}, 32'd1);
    chk("lw_rd", {27'd0, rd_e}, 32'd5);
    drv(32'h0020A423, 32'h0, 32'h100, 32'h55);
    tick;
    chk("sw_alu", alu_out_e, 32'h108);
    chk("sw_rw", {31'd0, reg_write_e}, 32'd0);
    // unknown opcode
    drv(32'h0000007F, 32'h0, 32'h0, 32'h0);
    chk("nop_pcsel", {30'd0, pcsel}, 32'd0);
    tick;
    chk("nop_rw", {31'd0, reg_write_e}, 32'd0);
    chk("nop_wb", {30'd0, wb_sel_e}, 32'd0);
    // flush with ADD decoded
    drv(32'h002081B3, 32'h40, 32'd1, 32'd2);
    flush_e = 1'b1;
    tick;
    flush_e = 1'b0;
    chk_ex_zero("flush");
    // LUI x5,0x12345 then mid-cycle reset
    drv(32'h123452B7, 32'h80, 32'h0, 32'h0);
    tick;
    chk("lui_alu", alu_out_e, 32'h12345000);
    #2 rst_n = 1'b0;
    #1;
    chk_ex_zero("midrst");
    // reset held over an edge overrides capture
    tick;
    chk("rst_hold_rw", {31'd0, reg_write_e}, 32'd0);
    chk("rst_hold_alu", alu_out_e, 32'd0);
    rst_n = 1'b1;
    // forwarding: BNE x1,x2 with rs1=3, rs2=5, alu_out_m=5, fwd1=1
    drv(32'hFE209CE3, 32'h100, 32'd3, 32'd5);
    alu_out_m = 32'd5;
    fwd1_d = 1'b1;
    #1;
`ifdef BRANCH_FWD_EN
    chk("fwd_bne", {30'd0, pcsel}, 32'd0);
`else
    chk("fwd_bne", {30'd0, pcsel}, 32'd2);
`endif
    drv(32'h000280E7, 32'h200, 32'h1003, 32'h0);
    alu_out_m = 32'h2001;
    #1;
`ifdef BRANCH_FWD_EN
    chk("fwd_jalr", jtarg, 32'h2000);
`else
    chk("fwd_jalr", jtarg, 32'h1002);
`endif
    fwd1_d = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_exec_unit.md
DECODE_EXEC_UNIT -- requirements
Module: decode_exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_d  in  32  decode-stage instruction
- pc_d  in  32  decode-stage PC
- rs1_d, rs2_d  in  32 each  register-file read data
- alu_out_m  in  32  memory-stage ALU result, used for branch forwarding
- fwd1_d, fwd2_d  in  1 each  branch-operand forward selects
- flush_e  in  1  bubble the execute register
- pcsel  out  2  next-PC select: 00 PC+4, 01 jump, 10 branch taken
- jtarg, btarg  out  32 each  jump target and branch target
- reg_write_e  out  1  execute-stage register-write enable
- wb_sel_e  out  2  execute-stage writeback select
- rd_e  out  5  execute-stage destination register
- funct3_e  out  3  execute-stage funct3
- pc_plus4_e  out  32  execute-stage PC+4
- alu_out_e  out  32  ALU result

Function
REQ-003 Decode SHALL be combinational from instr_d using the RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
REQ-004 Immediates SHALL be sign-extended, defined as follows:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
REQ-005 Operand A SHALL be selected by opcode:
- LUI: 0
- AUIPC, JAL: pc_d
- all other opcodes: rs1_d
REQ-006 Operand B SHALL be rs2_d for OP and BRANCH, and the immediate for all other opcodes.
REQ-007 ALU control SHALL come from funct3 and instr[30]:
- OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
- OP-IMM: the same set, except SUB is never selected
- LUI, AUIPC, LOAD, STORE, JAL, JALR: ADD
REQ-008 The ALU SHALL use XLEN-bit wrap-around arithmetic.
- Shift amount = B[4:0].
- SLT is a signed compare; SLTU is unsigned.
- SRA replicates bit 31.
REQ-009 reg_write SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP.
REQ-010 wb_sel SHALL be:
- 01 for LOAD
- 10 for JAL and JALR
- 00 otherwise
REQ-011 Jump target SHALL be:
- JAL: jtarg = pc_d + J-immediate
- JALR: jtarg = (rs1 + I-immediate) & ~1
REQ-012 Branch target SHALL be btarg = pc_d + B-immediate.
REQ-013 Branch resolution SHALL compare the branch operands using the funct3 condition: BEQ, BNE, BLT, BGE, BLTU or BGEU.
REQ-014 pcsel SHALL be:
- 01 for JAL and JALR
- 10 when a BRANCH opcode is taken
- 00 otherwise
pcsel is never 11.
REQ-015 An unknown opcode SHALL decode as a NOP: all enables 0, pcsel 00, ADD.
REQ-016 On each rising clk, the execute register SHALL capture operand A, operand B, ALU control, reg_write, wb_sel, rd, funct3 and pc_d+4.
REQ-017 alu_out_e SHALL be combinational from the execute register, giving 1-cycle latency from decode.
REQ-018 When flush_e=1 at a clock edge, the execute register SHALL load all zeros (a NOP).

Reset
REQ-019 When rst_n=0, the execute register SHALL clear to zero immediately, giving:
- reg_write_e = 0
- wb_sel_e = 00
- rd_e = 0
- funct3_e = 0
- pc_plus4_e = 0
- alu_out_e = 0
REQ-020 Reset SHALL take precedence over flush_e and over capture; a reset asserted mid-operation discards the in-flight instruction.

Configuration
REQ-021 With BRANCH_FWD_EN defined, the branch operands and the JALR base SHALL be alu_out_m when fwd1_d or fwd2_d (respectively) is 1, and rs1_d/rs2_d otherwise.
REQ-022 Without BRANCH_FWD_EN, rs1_d and rs2_d SHALL be used directly and fwd1_d/fwd2_d SHALL be ignored.

Structure
REQ-023 Package riscv_pkg SHALL hold the opcode constants, the ALU-control encoding (5-bit: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9), and the pcsel and wb_sel encodings.
REQ-024 The ALU SHALL be a single sub-module, alu_core; decode and branch logic stay in the top module.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ADDI x1,x0,-1, then capture edge -> alu_out_e=0xFFFFFFFF, reg_write_e=1, wb_sel_e=00.
- BEQ with rs1=rs2=5, pc_d=0x100, imm=-8 -> pcsel=10, btarg=0xF8; with rs2=6 -> pcsel=00.
- JALR with rs1=0x1003, imm=0 -> pcsel=01, jtarg=0x1002; after the edge, wb_sel_e=10 and pc_plus4_e=pc_d+4.
- SRAI by 4 on 0x80000000 -> alu_out_e=0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0.
- flush_e=1 with ADD decoded -> reg_write_e=0, alu_out_e=0.
- rst_n low mid-cycle -> all execute outputs 0 before the next edge.
- BRANCH_FWD_EN defined, BNE with fwd1_d=1, alu_out_m=rs2_d -> not taken.
